warp_pc_fetch: RTL

WARP_PC_FETCH -- requirements
Module: warp_pc_fetch

---
 rtl/warp_pc_fetch_if.sv | 33 +++
 rtl/warp_pc_fetch.sv | 94 +++++++++
 2 files changed

// File: rtl/warp_pc_fetch_if.sv
// Warp PC fetch port bundle: Task Manager launch, SIMT redirect/stall, IBuffer full,
// fetch request out to IF and per-warp active flags back to the Task Manager.
interface warp_pc_fetch_if #(
  parameter int PC_W = 10
);
  logic              Update_TM_PC;
  logic [2:0]        WarpID_TM_PC;
  logic [PC_W-1:0]   StartPC_TM_PC;
  logic [7:0]        Exit_ID_PC;
  logic [7:0]        UpdatePC_Qual1_SIMT_PC;
  logic [7:0]        UpdatePC_Qual2_SIMT_PC;
  logic [7:0]        Stall_SIMT_PC;
  logic [255:0]      TargetAddr_SIMT_PC_Flattened;
  logic [7:0]        Full_IB_PC;
  logic              Valid_PC_IF;
  logic [2:0]        WarpID_PC_IF;
  logic [PC_W-1:0]   PC_PC_IF;
  logic [7:0]        Active_PC_TM;

  modport master (
    output Update_TM_PC, WarpID_TM_PC, StartPC_TM_PC, Exit_ID_PC,
           UpdatePC_Qual1_SIMT_PC, UpdatePC_Qual2_SIMT_PC, Stall_SIMT_PC,
           TargetAddr_SIMT_PC_Flattened, Full_IB_PC,
    input  Valid_PC_IF, WarpID_PC_IF, PC_PC_IF, Active_PC_TM
  );

  modport slave (
    input  Update_TM_PC, WarpID_TM_PC, StartPC_TM_PC, Exit_ID_PC,
           UpdatePC_Qual1_SIMT_PC, UpdatePC_Qual2_SIMT_PC, Stall_SIMT_PC,
           TargetAddr_SIMT_PC_Flattened, Full_IB_PC,
    output Valid_PC_IF, WarpID_PC_IF, PC_PC_IF, Active_PC_TM
  );
endinterface

// File: rtl/warp_pc_fetch.sv
// Per-warp PC bank with round-robin fetch arbitration; one registered fetch request per cycle,
// 1-cycle latency, stalled/full/redirected warps simply drop out of arbitration.
module warp_pc_fetch #(
  parameter int PC_W      = 10,
  parameter int NUM_WARPS = 8
) (
  input  logic           clk,
  input  logic           rst,
  warp_pc_fetch_if.slave bus
);
  logic [PC_W-1:0]      pc     [NUM_WARPS];
  logic [PC_W-1:0]      pc_nxt [NUM_WARPS];
  logic [PC_W-1:0]      target [NUM_WARPS];
  logic [NUM_WARPS-1:0] active, active_nxt;
  logic [NUM_WARPS-1:0] launch_hit, elig;
  logic [2:0]           last_grant;
  logic                 grant_vld;
  logic [2:0]           grant_id;
  logic [2:0]           scan_idx;

  logic                 fetch_vld;
  logic [2:0]           fetch_wid;
  logic [PC_W-1:0]      fetch_pc;

  // Only the low PC_W bits of each 32-bit target lane are meaningful.
  logic [255:0] unused_target_bits;
  assign unused_target_bits = bus.TargetAddr_SIMT_PC_Flattened;

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      target[i]     = bus.TargetAddr_SIMT_PC_Flattened[32*i +: PC_W];
      launch_hit[i] = bus.Update_TM_PC && (bus.WarpID_TM_PC == 3'(i));
      elig[i]       = active[i] & ~bus.Stall_SIMT_PC[i] & ~bus.Full_IB_PC[i]
                    & ~bus.UpdatePC_Qual1_SIMT_PC[i] & ~bus.UpdatePC_Qual2_SIMT_PC[i]
                    & ~bus.Exit_ID_PC[i] & ~launch_hit[i];
    end
  end

  // Round-robin scan starting just after the last granted warp.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = last_grant;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      scan_idx = last_grant + 3'(k);
      if (!grant_vld && elig[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      pc_nxt[i]     = pc[i];
      active_nxt[i] = active[i];
      if (launch_hit[i])
        pc_nxt[i] = bus.StartPC_TM_PC;
      else if (bus.UpdatePC_Qual1_SIMT_PC[i] || bus.UpdatePC_Qual2_SIMT_PC[i])
        pc_nxt[i] = target[i];
      else if (grant_vld && (grant_id == 3'(i)))
        pc_nxt[i] = pc[i] + PC_W'(4);
      if (launch_hit[i])
        active_nxt[i] = 1'b1;
      else if (bus.Exit_ID_PC[i])
        active_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WARPS; i++) pc[i] <= '0;
      active     <= '0;
      last_grant <= 3'd7;
      fetch_vld  <= 1'b0;
      fetch_wid  <= '0;
      fetch_pc   <= '0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) pc[i] <= pc_nxt[i];
      active    <= active_nxt;
      fetch_vld <= grant_vld;
      if (grant_vld) begin
        last_grant <= grant_id;
        fetch_wid  <= grant_id;
        fetch_pc   <= pc[grant_id];
      end
    end
  end

  assign bus.Valid_PC_IF  = fetch_vld;
  assign bus.WarpID_PC_IF = fetch_wid;
  assign bus.PC_PC_IF     = fetch_pc;
  assign bus.Active_PC_TM = active;
endmodule
